// File: rtl/tva_pkg.sv
// Shared definitions for the flat-bus matrix datapath: the streaming state
// encoding and the single source of truth for how an element (r,c) is packed
// into a wide SEQ_LEN x EMB_DIM bus.
package tva_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } stream_state_e;

  // Base bit of element (r,c) in a row-major flat matrix bus.
  function automatic int flat_lsb(input int r, input int c,
                                  input int emb_dim, input int data_width);
    return (r * emb_dim + c) * data_width;
  endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major (row, column) position counter. Clear has priority over advance;
// the counter parks on the final element instead of wrapping, so the owner
// decides what happens after the last position.
module rc_counter #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_col_o,
  output logic          last_o
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          last_col_s;
  logic          last_s;

  // Decode end-of-row and end-of-matrix from the registered position.
  always_comb begin
    last_col_s = (col_q == COL_MAX);
    last_s     = last_col_s && (row_q == ROW_MAX);
  end

  // Next position: clear, step row-major, or hold (including at the end).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i && !last_s) begin
      if (last_col_s) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign last_col_o = last_col_s;
  assign last_o     = last_s;

endmodule

// File: rtl/mat_stream_out.sv
// Snapshots a whole flat SEQ_LEN x EMB_DIM matrix on start and streams it out
// row-major, one element per valid/ready handshake, with row-end and
// matrix-end markers and a one-cycle done pulse. Outputs depend only on
// registered state, so m_ready never reaches an output combinationally.
module mat_stream_out
  import tva_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int SEQ_LEN    = 8,
  parameter  int EMB_DIM    = 8,
  localparam int MAT_W      = DATA_WIDTH * SEQ_LEN * EMB_DIM,
  localparam int RW         = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int CW         = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MAT_W-1:0]      mat_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RW-1:0]         m_row,
  output logic [CW-1:0]         m_col,
  output logic                  m_last_col,
  output logic                  m_last
);

  stream_state_e   state_q, state_d;
  logic [MAT_W-1:0] buf_q, buf_d;
  logic            valid_q;
  logic            done_q;

  logic            clr_s;
  logic            adv_s;
  logic [RW-1:0]   row_s;
  logic [CW-1:0]   col_s;
  logic            last_col_s;
  logic            last_s;
  logic [DATA_WIDTH-1:0] elem_s;

  rc_counter #(
    .ROWS (SEQ_LEN),
    .COLS (EMB_DIM),
    .RW   (RW),
    .CW   (CW)
  ) u_rc_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_s),
    .adv_i      (adv_s),
    .row_o      (row_s),
    .col_o      (col_s),
    .last_col_o (last_col_s),
    .last_o     (last_s)
  );

  // Stream control: capture on start when idle or just finished, advance on
  // each handshake, and leave on the handshake of the final element. The
  // counter is cleared on that final handshake so it never wraps.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    clr_s   = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = mat_in;
          clr_s   = 1'b1;
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (m_ready) begin
          adv_s = 1'b1;
          if (last_s) begin
            clr_s   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        if (start) begin
          buf_d   = mat_in;
          clr_s   = 1'b1;
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, snapshot buffer and registered valid/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      valid_q <= (state_d == S_STREAM);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Select the current element out of the snapshot using the shared packing rule.
  always_comb begin
    elem_s = buf_q[flat_lsb(int'(row_s), int'(col_s), EMB_DIM, DATA_WIDTH) +: DATA_WIDTH];
  end

  assign m_data     = elem_s;
  assign m_valid    = valid_q;
  assign busy       = valid_q;
  assign done       = done_q;
  assign m_row      = row_s;
  assign m_col      = col_s;
  assign m_last_col = valid_q & last_col_s;
  assign m_last     = valid_q & last_s;

endmodule
